spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_rx_fifo.sv | 55 +++++
 rtl/spi_slave_rx.sv | 130 +++++++++++++
 tb/tb_spi_slave_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI receive slice.
`timescale 1ns/1ps
package spi_pkg;
  localparam int SPI_WORD_W      = 8;
  localparam int SPI_CNT_W       = 3;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  function automatic logic rise_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction
endpackage

// File: rtl/spi_rx_fifo.sv
// Single-clock show-ahead byte buffer with full/empty flags.
`timescale 1ns/1ps
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [SPI_WORD_W-1:0] wr_data,
  input  logic                  rd_en,
  output logic [SPI_WORD_W-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [SPI_WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_fire, rd_fire;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a push at full still lands.
  always_comb begin
    rd_fire  = rd_en & ~empty;
    wr_fire  = wr_en & (~full | rd_fire);
    wr_ptr_d = wr_ptr_q + AW'(wr_fire);
    rd_ptr_d = rd_ptr_q + AW'(rd_fire);
    count_d  = count_q + CW'(wr_fire) - CW'(rd_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive-only slave: synchronizers, edge detect, framing FSM,
// shift register and a byte buffer toward the m_clk consumer.
`timescale 1ns/1ps
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  m_clk,
  input  logic                  rst,
  input  logic                  spi_clk,
  input  logic                  spi_cs,
  input  logic                  spi_mosi_in,
  input  logic                  data_rd,
  output logic [SPI_WORD_W-1:0] data_out,
  output logic                  data_av,
  output logic                  overrun,
  output logic                  frame_err
);
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, cs_hist_q;
  logic                   sclk_s, cs_s, mosi_s;

  spi_state_e             state_q, state_d;
  logic [SPI_CNT_W-1:0]   cnt_q, cnt_d;
  // The eighth bit goes straight into the buffer, so only seven are held.
  logic [SPI_WORD_W-2:0]  shift_q, shift_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic                   sample, cs_fall, cs_rise, push;
  logic [SPI_WORD_W-1:0]  push_data;
  logic                   fifo_full, fifo_empty;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_in};
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Synchronizers preset to the bus idle levels so reset never fakes an edge.
  always_ff @(posedge m_clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
    end
  end

  always_comb begin
    cs_fall     = rise_edge(cs_hist_q, cs_s);
    cs_rise     = rise_edge(cs_s, cs_hist_q);
    sample      = (state_q == SHIFT) & rise_edge(sclk_s, sclk_hist_q) & ~cs_s;
    push_data   = {shift_q, mosi_s};
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (cnt_q != '0);
        end else if (sample) begin
          shift_d = push_data[SPI_WORD_W-2:0];
          cnt_d   = cnt_q + 1'b1;
          push    = (cnt_q == '1);
        end
      end
      default: state_d = IDLE;
    endcase
    overrun_d = overrun_q | (push & fifo_full & ~data_rd);
  end

  always_ff @(posedge m_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  spi_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (m_clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (data_rd),
    .rd_data (data_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign data_av   = ~fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: 100 MHz m_clk, 5 MHz mode-0 SPI master.
`timescale 1ns/1ps
module tb_spi_slave_rx;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int HALF  = 100;

  logic       m_clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_mosi_in = 1'b0;
  logic       data_rd = 1'b0;
  logic [7:0] data_out;
  logic       data_av, overrun, frame_err;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;
  int         fe_cycles = 0;
  int         fe_events = 0;
  logic       fe_prev = 1'b0;

  spi_slave_rx #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .m_clk       (m_clk),
    .rst         (rst),
    .spi_clk     (spi_clk),
    .spi_cs      (spi_cs),
    .spi_mosi_in (spi_mosi_in),
    .data_rd     (data_rd),
    .data_out    (data_out),
    .data_av     (data_av),
    .overrun     (overrun),
    .frame_err   (frame_err)
  );

  always #5 m_clk = ~m_clk;

  always @(negedge m_clk) begin
    if (frame_err === 1'b1) fe_cycles <= fe_cycles + 1;
    if (frame_err === 1'b1 && fe_prev !== 1'b1) fe_events <= fe_events + 1;
    fe_prev <= frame_err;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish, %0d checks run", n_tests);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cs_low();
    @(posedge m_clk);
    #2;
    spi_cs = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    spi_cs = 1'b1;
    #(2*HALF);
  endtask

  // mode 0: plain; 1: check data_av latency on 8th edge; 2: pop in the push cycle
  task automatic send_bits(input logic [7:0] b, input int nbits, input int mode);
    logic [7:0] tmp;
    int seen;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi_in = b[7-i];
      #HALF;
      spi_clk = 1'b1;
      if (i == 7 && mode == 1) begin
        seen = 0;
        for (int k = 0; k < SYNC + 2; k++) begin
          @(posedge m_clk);
          #1;
          if (k == 0) check_eq("lat_av_early", {31'd0, data_av}, 32'd0);
          if (data_av === 1'b1 && seen == 0) seen = k + 1;
        end
        check_eq("lat_av_window", {31'd0, seen != 0}, 32'd1);
        #(HALF - 10*(SYNC+2) + 1);
      end else if (i == 7 && mode == 2) begin
        repeat (SYNC) @(posedge m_clk);
        #1;
        check_eq("cc_head", {24'd0, data_out}, {24'd0, exp_q[0]});
        data_rd = 1'b1;
        tmp = exp_q.pop_front();
        @(posedge m_clk);
        #1;
        data_rd = 1'b0;
        #(HALF - 10*(SYNC+1) + 1);
      end else begin
        #HALF;
      end
      spi_clk = 1'b0;
    end
    if (nbits == 8) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    @(posedge m_clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_empty_av"}, {31'd0, data_av}, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_av"}, {31'd0, data_av}, 32'd1);
      check_eq({tag, "_data"}, {24'd0, data_out}, {24'd0, e});
    end
    data_rd = 1'b1;
    @(posedge m_clk);
    #1;
    data_rd = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data_out"}, {24'd0, data_out}, 32'd0);
    check_eq({tag, "_data_av"}, {31'd0, data_av}, 32'd0);
    check_eq({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    check_eq({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    int fe0, fc0;
    logic [7:0] seq34 [4];
    seq34 = '{8'h01, 8'h80, 8'hFF, 8'h3C};

    repeat (4) @(posedge m_clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;
    repeat (4) @(posedge m_clk);

    // Single byte with latency check
    fe0 = fe_events;
    cs_low();
    send_bits(8'hA5, 8, 1);
    cs_high();
    check_eq("a5_no_fe", fe_events - fe0, 32'd0);
    pop_check("a5");
    pop_check("a5_after");

    // Four bytes back to back in one frame
    cs_low();
    for (int i = 0; i < 4; i++) send_bits(seq34[i], 8, 0);
    cs_high();
    check_eq("four_ovr", {31'd0, overrun}, {31'd0, exp_ovr});
    for (int i = 0; i < 4; i++) pop_check("four");
    pop_check("four_after");

    // Partial frame then a good one
    fe0 = fe_events;
    fc0 = fe_cycles;
    cs_low();
    send_bits(8'hF0, 5, 0);
    cs_high();
    check_eq("part_fe_events", fe_events - fe0, 32'd1);
    check_eq("part_fe_width", fe_cycles - fc0, 32'd1);
    check_eq("part_no_push", {31'd0, data_av}, 32'd0);
    cs_low();
    send_bits(8'h5A, 8, 0);
    cs_high();
    check_eq("5a_fe", fe_events - fe0, 32'd1);
    pop_check("5a");

    // Full buffer, pop coinciding with the 5th byte's push
    cs_low();
    for (int i = 0; i < 4; i++) send_bits(8'h21 + 8'(i), 8, 0);
    send_bits(8'h25, 8, 2);
    cs_high();
    check_eq("cc_ovr", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 4; i++) pop_check("cc");
    pop_check("cc_after");

    // Overrun: five bytes, no pops
    cs_low();
    for (int i = 0; i < 5; i++) send_bits(8'h11 + 8'(i), 8, 0);
    cs_high();
    check_eq("ovr_set", {31'd0, overrun}, {31'd0, exp_ovr});
    check_eq("ovr_model", {31'd0, exp_ovr}, 32'd1);
    for (int i = 0; i < 4; i++) pop_check("ovr");
    pop_check("ovr_after");
    check_eq("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset mid-frame with data buffered and overrun set
    cs_low();
    send_bits(8'h77, 8, 0);
    send_bits(8'hE7, 3, 0);
    fe0 = fe_events;
    @(posedge m_clk);
    #1;
    rst = 1'b1;
    spi_cs = 1'b1;
    @(posedge m_clk);
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) @(posedge m_clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    exp_q.delete();
    exp_ovr = 1'b0;
    repeat (6) @(posedge m_clk);
    #1;
    check_eq("rst_no_fe", fe_events - fe0, 32'd0);
    check_eq("rst_av", {31'd0, data_av}, 32'd0);
    cs_low();
    send_bits(8'hC3, 8, 0);
    cs_high();
    check_eq("c3_no_fe", fe_events - fe0, 32'd0);
    check_eq("c3_ovr", {31'd0, overrun}, 32'd0);
    pop_check("c3");
    pop_check("c3_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
